// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/DMA memory arbiter.
// Imported by mem_arbiter and by anything that instantiates it.
package mem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int BURST_MAX_DEF = 4;
    localparam int BURST_W       = 4;

    typedef logic [BURST_W-1:0] burst_t;

    // Count value at which the current grant is the final one of a tenure.
    function automatic burst_t burst_limit(input int max);
        return BURST_W'(max - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU core and a DMA requester.
// The CPU stalls (cpu_rdy=0) whenever DMA owns the bus.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic        dma_last,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    owner_e     state;
    burst_t     burst_cnt;
    logic       last_cpu;
    logic [7:0] hold_q;
    logic       own_cpu;
    logic       burst_end;

    assign own_cpu   = (state == OWN_CPU);
    assign cpu_rdy   = own_cpu;
    assign dma_gnt   = !own_cpu && dma_req;
    assign burst_end = dma_last || (burst_cnt == burst_limit(BURST_MAX));

    // Only the owning side ever reaches the RAM write strobe.
    assign mem_addr  = own_cpu ? cpu_addr : dma_addr;
    assign mem_wdata = own_cpu ? cpu_dout : dma_wdata;
    assign mem_we    = own_cpu ? cpu_we   : (dma_we && dma_req);

    assign dma_rdata = mem_rdata;
    assign cpu_din   = last_cpu ? mem_rdata : hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= OWN_CPU;
            burst_cnt <= '0;
            last_cpu  <= 1'b1;
            hold_q    <= 8'h00;
            dma_ack   <= 1'b0;
        end else begin
            last_cpu <= own_cpu;
            dma_ack  <= dma_gnt;
            if (last_cpu) begin
                hold_q <= mem_rdata;
            end
            case (state)
                OWN_CPU: begin
                    burst_cnt <= '0;
                    if (dma_req) begin
                        state <= OWN_DMA;
                    end
                end
                OWN_DMA: begin
                    if (!dma_req) begin
                        state     <= OWN_CPU;
                        burst_cnt <= '0;
                    end else if (burst_end) begin
                        state     <= OWN_CPU;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= OWN_CPU;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a bus-ownership
// model with a shadow RAM.
module tb_mem_arbiter;

    localparam int BM = 4;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic        last;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        dma_req = 1'b0;
    logic        dma_last = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_we = 1'b0;
    logic        dma_gnt;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  ram [0:65535] = '{default: 8'h00};

    mem_arbiter #(.BURST_MAX(BM)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_we    (cpu_we),
        .cpu_din   (cpu_din),
        .cpu_rdy   (cpu_rdy),
        .dma_req   (dma_req),
        .dma_last  (dma_last),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .dma_gnt   (dma_gnt),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    // Behavioural model: who owns the bus, grants so far this tenure,
    // and a shadow copy of RAM giving the data every read must return.
    bit          m_dma = 1'b0;
    int          m_run = 0;
    bit          m_prev_gnt = 1'b0;
    bit          m_prev_we = 1'b0;
    logic [7:0]  m_prev_rd = 8'h00;
    logic [7:0]  m_cpu_data = 8'h00;
    logic [7:0]  mm [0:65535] = '{default: 8'h00};
    bit          seen_gnt = 1'b0;

    always @(negedge clk) begin
        logic [15:0] ea;
        logic [7:0]  ew;
        logic [7:0]  rd;
        logic        ewe;
        logic        egnt;
        if (reset) begin
            m_dma      = 1'b0;
            m_run      = 0;
            m_prev_gnt = 1'b0;
        end
        egnt = m_dma && dma_req;
        ea   = m_dma ? dma_addr  : cpu_addr;
        ew   = m_dma ? dma_wdata : cpu_dout;
        ewe  = m_dma ? (dma_we && dma_req) : cpu_we;
        seen_gnt = dma_gnt;
        if (chk_en) begin
            chk("cpu_rdy", 32'(cpu_rdy), 32'(!m_dma));
            chk("dma_gnt", 32'(dma_gnt), 32'(egnt));
            chk("dma_ack", 32'(dma_ack), 32'(m_prev_gnt));
            chk("mem_addr", 32'(mem_addr), 32'(ea));
            chk("mem_wdata", 32'(mem_wdata), 32'(ew));
            chk("mem_we", 32'(mem_we), 32'(ewe));
            if (m_prev_gnt && !m_prev_we)
                chk("dma_rdata", 32'(dma_rdata), 32'(m_prev_rd));
            if (!reset)
                chk("cpu_din", 32'(cpu_din), 32'(m_cpu_data));
        end
        rd = mm[ea];
        if (ewe) mm[ea] = ew;
        if (!m_dma) m_cpu_data = rd;
        m_prev_gnt = egnt;
        m_prev_we  = dma_we;
        m_prev_rd  = rd;
        if (!reset) begin
            if (!m_dma) begin
                m_run = 0;
                m_dma = dma_req;
            end else if (!dma_req) begin
                m_dma = 1'b0;
            end else begin
                m_run++;
                if (dma_last || m_run >= BM) m_dma = 1'b0;
            end
        end
    end

    // Requester and CPU drive, applied just after each rising edge.
    xfer_t       dq[$];
    logic [15:0] pc_addr = '0;
    logic [7:0]  pc_dout = '0;
    logic        pc_we = 1'b0;
    bit          drop_plan = 1'b0;
    bit          rst_plan = 1'b0;

    task automatic next();
        @(posedge clk);
        #1;
        reset    = rst_plan;
        cpu_addr = pc_addr;
        cpu_dout = pc_dout;
        cpu_we   = pc_we;
        if (rst_plan) begin
            dq.delete();
            dma_req = 1'b0;
        end else begin
            if (seen_gnt && dq.size() > 0) void'(dq.pop_front());
            if (dq.size() > 0) begin
                dma_addr  = dq[0].a;
                dma_wdata = dq[0].d;
                dma_we    = dq[0].we;
                dma_last  = dq[0].last;
                dma_req   = !drop_plan;
            end else begin
                dma_req = 1'b0;
            end
        end
    endtask

    logic [15:0] rdy_v, gnt_v, ack_v, we_v;
    logic [7:0]  din_v [16];
    logic [15:0] addr_v [16];
    logic [7:0]  acks[$];

    task automatic run_log(int n, logic [15:0] dm, logic [15:0] rm);
        rdy_v = '0; gnt_v = '0; ack_v = '0; we_v = '0;
        acks.delete();
        for (int i = 0; i < n; i++) begin
            drop_plan = dm[i];
            rst_plan  = rm[i];
            next();
            @(negedge clk);
            rdy_v[i]  = cpu_rdy;
            gnt_v[i]  = dma_gnt;
            ack_v[i]  = dma_ack;
            we_v[i]   = mem_we;
            din_v[i]  = cpu_din;
            addr_v[i] = mem_addr;
            if (dma_ack) acks.push_back(dma_rdata);
        end
        drop_plan = 1'b0;
        rst_plan  = 1'b0;
    endtask

    task automatic preload(logic [15:0] a, logic [7:0] v);
        pc_addr = a; pc_dout = v; pc_we = 1'b1;
        next();
        pc_we = 1'b0;
    endtask

    task automatic push(logic [15:0] a, logic [7:0] d, logic we, logic last);
        xfer_t x;
        x.a = a; x.d = d; x.we = we; x.last = last;
        dq.push_back(x);
    endtask

    initial begin
        rst_plan = 1'b1;
        next();
        chk_en = 1'b1;
        run_log(2, '0, 16'h3);
        chk("reset rdy", 32'(rdy_v[1:0]), 32'h3);
        chk("reset gnt", 32'(gnt_v[1:0]), 32'h0);
        chk("reset ack", 32'(ack_v[1:0]), 32'h0);
        run_log(1, '0, '0);

        // Idle DMA CPU read
        preload(16'h1234, 8'hA5);
        pc_addr = 16'h1234;
        run_log(2, '0, '0);
        chk("idle rdy", 32'(rdy_v[1:0]), 32'h3);
        chk("idle din", 32'(din_v[1]), 32'hA5);

        // Single DMA write
        pc_addr = 16'h0777;
        push(16'h0200, 8'h3C, 1'b1, 1'b1);
        run_log(4, '0, '0);
        chk("single rdy", 32'(rdy_v[3:0]), 32'b1101);
        chk("single gnt", 32'(gnt_v[3:0]), 32'b0010);
        chk("single ack", 32'(ack_v[3:0]), 32'b0100);
        chk("single cpu addr", 32'(addr_v[2]), 32'h0777);
        chk("single ram", 32'(ram[16'h0200]), 32'h3C);

        // Six-read burst split by BURST_MAX
        for (int i = 0; i < 6; i++) preload(16'h0300 + 16'(i), 8'h10 + 8'(i));
        pc_addr = 16'h0777;
        for (int i = 0; i < 6; i++) push(16'h0300 + 16'(i), 8'h00, 1'b0, i == 5);
        run_log(10, '0, '0);
        chk("burst gnt", 32'(gnt_v[9:0]), 32'h0DE);
        chk("burst rdy", 32'(rdy_v[9:0]), 32'h321);
        chk("burst ack", 32'(ack_v[9:0]), 32'h1BC);
        chk("burst ack count", 32'(acks.size()), 32'd6);
        for (int i = 0; i < 6 && i < acks.size(); i++)
            chk("burst ack data", 32'(acks[i]), 32'h10 + 32'(i));

        // Read data held across a stall
        preload(16'h0400, 8'h5A);
        pc_addr = 16'h0400;
        for (int i = 0; i < 3; i++) push(16'h0500 + 16'(i), 8'hC0, 1'b1, i == 2);
        run_log(5, '0, '0);
        chk("stall rdy", 32'(rdy_v[4:0]), 32'b10001);
        for (int i = 1; i < 5; i++) chk("stall din", 32'(din_v[i]), 32'h5A);

        // Request dropped while DMA owns the bus
        pc_addr = 16'h0777;
        push(16'h0600, 8'h77, 1'b1, 1'b1);
        run_log(5, 16'b00010, '0);
        chk("drop rdy", 32'(rdy_v[4:0]), 32'b10101);
        chk("drop gnt", 32'(gnt_v[4:0]), 32'b01000);
        chk("drop ack", 32'(ack_v[4:0]), 32'b10000);
        chk("drop we", 32'(we_v[4:0]), 32'b01000);

        // Reset during the second of four burst writes
        push(16'h0700, 8'h11, 1'b1, 1'b0);
        push(16'h0701, 8'h22, 1'b1, 1'b0);
        push(16'h0702, 8'h33, 1'b1, 1'b0);
        push(16'h0703, 8'h44, 1'b1, 1'b1);
        run_log(5, '0, 16'b00100);
        chk("rst rdy", 32'(rdy_v[4:0]), 32'b11101);
        chk("rst gnt", 32'(gnt_v[4:0]), 32'b00010);
        chk("rst ack", 32'(ack_v[4:0]), 32'b00000);
        chk("rst we", 32'(we_v[4:0]), 32'b00010);
        chk("rst ram0", 32'(ram[16'h0700]), 32'h11);
        chk("rst ram1", 32'(ram[16'h0701]), 32'h00);
        chk("rst ram2", 32'(ram[16'h0702]), 32'h00);
        chk("rst ram3", 32'(ram[16'h0703]), 32'h00);

        // Random traffic on a small shared address window
        for (int c = 0; c < 3000; c++) begin
            if (dq.size() == 0 && $urandom_range(0, 5) == 0) begin
                int n = $urandom_range(1, 8);
                for (int k = 0; k < n; k++)
                    push(16'($urandom_range(0, 63)), 8'($urandom),
                         1'($urandom_range(0, 1)), k == n - 1);
            end
            pc_addr   = 16'($urandom_range(0, 63));
            pc_dout   = 8'($urandom);
            pc_we     = ($urandom_range(0, 3) == 0);
            drop_plan = ($urandom_range(0, 9) == 0);
            rst_plan  = ($urandom_range(0, 299) == 0);
            next();
        end
        rst_plan  = 1'b0;
        drop_plan = 1'b0;
        pc_we     = 1'b0;
        run_log(3, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
